timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
Controller for the keypad countdown timer. It scans a 4x3 keypad, debounces key presses, and builds a 4-digit BCD MM:SS entry. It runs the countdown and drives the alarm. Its min_sec output feeds the 4-digit display driver directly, and it replaces the ad-hoc load/minute logic in the timer top level.

Parameters:
DEBOUNCE_SCANS, 4, number of consecutive identical full scans (4 rows each) needed to accept a press or a release
ALARM_SECS, 10, number of tick_1hz pulses the alarm stays asserted

Ports:
clk  in  1  system clock (4 MHz)
reset  in  1  synchronous, active-high reset
scan_tick  in  1  one-clk strobe that advances the keypad scan by one row
tick_1hz  in  1  one-clk strobe, once per second
keypadc  in  3  keypad columns, active-high; bit0 = left column
keypadr  out  4  keypad row drive, one-hot active-high; bit0 = top row
min_sec  out  16  BCD digits [15:12]=M tens, [11:8]=M units, [7:4]=S tens, [3:0]=S units
points  out  4  display decimal points; only bit2 (colon) is ever set
running  out  1  high in RUN state
alarm  out  1  high in ALARM state

Behaviour:
- Reset values: keypadr=4'b0001, min_sec=16'h0000, points=4'b0100, running=0, alarm=0, state=IDLE. Scan and debounce state cleared.
- Keypad map:
  - rows 0-2, cols 0-2 = digits 1-9, row-major;
  - row3: col0 = CLR (*), col1 = digit 0, col2 = GO (#).
- Scan:
  - on scan_tick, sample keypadc against the current row, then rotate keypadr left (0001->0010->0100->1000->0001);
  - a full scan is 4 scan_ticks starting at row0;
  - the scan result is the lowest-numbered pressed key (row first, then column), or NONE;
  - multiple keys in one scan resolve to that lowest key.
- Debounce:
  - a press is accepted when the same key is the result of DEBOUNCE_SCANS consecutive full scans while in the released condition;
  - on acceptance, generate a one-clk key event in the clk cycle after the completing scan_tick;
  - afterwards, no new event until NONE is seen for DEBOUNCE_SCANS consecutive scans, so holding a key yields exactly one event.
- FSM, states IDLE, RUN, PAUSE, ALARM:
  - IDLE:
    - digit key: min_sec <= {min_sec[11:0], digit}, shifting left and dropping the oldest digit;
    - CLR: min_sec <= 0;
    - GO with min_sec != 0: clamp seconds (if S tens > 5, set seconds to 59), then go to RUN;
    - GO with min_sec == 0: ignored.
  - RUN:
    - on tick_1hz, BCD decrement:
      - S units 0 -> 9 with borrow from S tens; S tens 0 -> 5 with borrow from minutes;
      - minutes decrement in BCD (M units 0 -> 9, borrow from M tens);
    - if the decrement reaches 0000, go to ALARM in the same cycle;
    - GO -> PAUSE; CLR -> IDLE with min_sec = 0; digit keys ignored.
  - PAUSE: count frozen. GO -> RUN; CLR -> IDLE with min_sec = 0; digits ignored.
  - ALARM:
    - alarm=1, min_sec = 0000;
    - the alarm counter counts tick_1hz pulses; after ALARM_SECS of them, or on any key event, go to IDLE;
    - alarm drops in the same cycle the state leaves ALARM.
- Colon: points[2]=1 in IDLE/PAUSE/ALARM. In RUN it toggles on every tick_1hz, and is set to 1 on entry to RUN.
- Simultaneous key event and tick_1hz in RUN: apply the decrement first, then the key action. GO therefore pauses with the decremented value; CLR wins and clears.
- A key event and tick_1hz are processed in the same clk; no event is lost.
- Reset mid-countdown or mid-alarm returns immediately to reset values.

Test Plan:
- Reset -> keypadr=0001, min_sec=0000, running=0, alarm=0. Then 8 scan_ticks -> keypadr sequence 0010,0100,1000,0001,... repeating.
- Press keys 1,2,3,0 (each held >= DEBOUNCE_SCANS scans, then released) -> min_sec=16'h1230. Then GO -> running=1. After 1 tick_1hz -> 16'h1229.
- Load 0100 and run -> 1 tick gives 0059. Load 1000 -> 1 tick gives 0959.
- Load 0001 and run, 1 tick -> ALARM, alarm=1. After ALARM_SECS=10 ticks -> alarm=0, IDLE.
- Key bounce: key 5 present for 3 scans, absent 1, present 3 -> no event. Key 5 held for 20 scans -> exactly one event (min_sec shifts once).
- Edge cases:
  - entry 0075, GO -> clamped to 0059 before counting;
  - GO coincident with tick_1hz at 0010 -> PAUSE holding 0009;
  - GO at 0000 in IDLE -> stays IDLE.

Source files
------------

// File: rtl/timer_ctrl.sv
// Keypad countdown timer controller: 4x3 keypad scan + debounce, BCD MM:SS entry,
// countdown FSM (IDLE/RUN/PAUSE/ALARM) and alarm timing.
module timer_ctrl #(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int ALARM_SECS     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_tick,
  input  logic        tick_1hz,
  input  logic [2:0]  keypadc,
  output logic [3:0]  keypadr,
  output logic [15:0] min_sec,
  output logic [3:0]  points,
  output logic        running,
  output logic        alarm
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW = $clog2(ALARM_SECS + 1);

  // Key codes are row*3+col; keys 0..8 are digits 1..9
  localparam logic [3:0] K_CLR  = 4'd9;
  localparam logic [3:0] K_ZERO = 4'd10;
  localparam logic [3:0] K_GO   = 4'd11;
  localparam logic [3:0] K_NONE = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_t;

  // ---------------- scan ----------------
  logic [1:0] row;
  logic [3:0] scan_acc;
  logic [3:0] row_key;
  logic [3:0] scan_res;
  logic       scan_done;

  assign keypadr = 4'b0001 << row;

  always_comb begin
    row_key = K_NONE;
    for (int c = 2; c >= 0; c--)
      if (keypadc[c]) row_key = 4'(int'(row) * 3 + c);
  end

  // Row 0 starts a fresh scan; later rows only fill in if nothing lower was seen
  assign scan_res  = (row == 2'd0 || scan_acc == K_NONE) ? row_key : scan_acc;
  assign scan_done = scan_tick && (row == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      row      <= 2'd0;
      scan_acc <= K_NONE;
    end else if (scan_tick) begin
      row      <= row + 2'd1;
      scan_acc <= scan_res;
    end
  end

  // ---------------- debounce ----------------
  logic          held;
  logic [3:0]    last_key;
  logic [CW-1:0] db_cnt;
  logic [CW:0]   cnt_inc;
  logic [CW:0]   press_n;
  logic          key_evt;
  logic [3:0]    key_code;

  assign cnt_inc = {1'b0, db_cnt} + 1'b1;
  assign press_n = (scan_res == last_key) ? cnt_inc : (CW+1)'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      held     <= 1'b0;
      last_key <= K_NONE;
      db_cnt   <= '0;
      key_evt  <= 1'b0;
      key_code <= K_NONE;
    end else begin
      key_evt <= 1'b0;
      if (scan_done) begin
        if (!held) begin
          if (scan_res == K_NONE) begin
            db_cnt   <= '0;
            last_key <= K_NONE;
          end else if (int'(press_n) >= DEBOUNCE_SCANS) begin
            key_evt  <= 1'b1;
            key_code <= scan_res;
            held     <= 1'b1;
            db_cnt   <= '0;
          end else begin
            db_cnt   <= press_n[CW-1:0];
            last_key <= scan_res;
          end
        end else begin
          // Held: wait for a run of empty scans before re-arming
          if (scan_res != K_NONE) begin
            db_cnt <= '0;
          end else if (int'(cnt_inc) >= DEBOUNCE_SCANS) begin
            held     <= 1'b0;
            db_cnt   <= '0;
            last_key <= K_NONE;
          end else begin
            db_cnt <= cnt_inc[CW-1:0];
          end
        end
      end
    end
  end

  // ---------------- key decode ----------------
  logic       is_digit, is_clr, is_go;
  logic [3:0] digit;

  assign is_digit = key_evt && (key_code <= 4'd8 || key_code == K_ZERO);
  assign is_clr   = key_evt && (key_code == K_CLR);
  assign is_go    = key_evt && (key_code == K_GO);
  assign digit    = (key_code == K_ZERO) ? 4'd0 : key_code + 4'd1;

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] su, st, mu, mt;
    {mt, mu, st, su} = v;
    if (su != 4'd0) su = su - 4'd1;
    else begin
      su = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mu != 4'd0) mu = mu - 4'd1;
        else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  // ---------------- FSM ----------------
  state_t        state, state_n;
  logic [15:0]   ms_n, ms_dec;
  logic          colon, colon_n;
  logic [AW-1:0] acnt, acnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      min_sec <= 16'h0000;
      colon   <= 1'b1;
      acnt    <= '0;
    end else begin
      state   <= state_n;
      min_sec <= ms_n;
      colon   <= colon_n;
      acnt    <= acnt_n;
    end
  end

  always_comb begin
    state_n = state;
    ms_n    = min_sec;
    colon_n = 1'b1;
    acnt_n  = acnt;
    ms_dec  = bcd_dec(min_sec);
    case (state)
      S_IDLE: begin
        if (is_digit)      ms_n = {min_sec[11:0], digit};
        else if (is_clr)   ms_n = 16'h0000;
        else if (is_go && min_sec != 16'h0000) begin
          state_n = S_RUN;
          if (min_sec[7:4] > 4'd5) ms_n[7:0] = 8'h59;
        end
      end
      S_RUN: begin
        colon_n = colon;
        // Decrement is applied first; the key action then acts on the result
        if (tick_1hz) begin
          ms_n    = ms_dec;
          colon_n = ~colon;
        end
        if (is_clr) begin
          state_n = S_IDLE;
          ms_n    = 16'h0000;
          colon_n = 1'b1;
        end else if (tick_1hz && ms_dec == 16'h0000) begin
          state_n = S_ALARM;
          ms_n    = 16'h0000;
          colon_n = 1'b1;
          acnt_n  = '0;
        end else if (is_go) begin
          state_n = S_PAUSE;
          colon_n = 1'b1;
        end
      end
      S_PAUSE: begin
        if (is_go) state_n = S_RUN;
        else if (is_clr) begin
          state_n = S_IDLE;
          ms_n    = 16'h0000;
        end
      end
      S_ALARM: begin
        ms_n = 16'h0000;
        if (key_evt) begin
          state_n = S_IDLE;
          acnt_n  = '0;
        end else if (tick_1hz) begin
          if (int'(acnt) >= ALARM_SECS - 1) begin
            state_n = S_IDLE;
            acnt_n  = '0;
          end else begin
            acnt_n = acnt + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign points  = {1'b0, colon, 2'b00};
  assign running = (state == S_RUN);
  assign alarm   = (state == S_ALARM);

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: keypad model driven by key_idx, hand-computed expectations.
module tb_timer_ctrl;

  localparam int DEB = 4;
  localparam int ASECS = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_tick;
  logic        tick_1hz;
  logic [2:0]  keypadc;
  logic [3:0]  keypadr;
  logic [15:0] min_sec;
  logic [3:0]  points;
  logic        running;
  logic        alarm;

  int total = 0;
  int bad   = 0;
  int key_idx = -1;

  timer_ctrl #(.DEBOUNCE_SCANS(DEB), .ALARM_SECS(ASECS)) dut (
    .clk(clk), .reset(reset), .scan_tick(scan_tick), .tick_1hz(tick_1hz),
    .keypadc(keypadc), .keypadr(keypadr), .min_sec(min_sec), .points(points),
    .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Physical keypad: the pressed key shorts its row to its column
  always_comb begin
    keypadc = 3'b000;
    if (key_idx >= 0 && keypadr[key_idx / 3]) keypadc[key_idx % 3] = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic stick();
    @(negedge clk) scan_tick = 1'b1;
    @(negedge clk) scan_tick = 1'b0;
  endtask

  task automatic scans(input int n);
    repeat (4 * n) stick();
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input int k);
    key_idx = k;
    scans(DEB + 1);
    key_idx = -1;
    scans(DEB + 1);
  endtask

  task automatic press_digit(input int d);
    press((d == 0) ? 10 : d - 1);
  endtask

  task automatic tick1();
    @(negedge clk) tick_1hz = 1'b1;
    @(negedge clk) tick_1hz = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    scan_tick = 1'b0;
    tick_1hz  = 1'b0;
    do_reset();
    chk("rst_keypadr", 32'(keypadr), 32'h1);
    chk("rst_min_sec", 32'(min_sec), 32'h0);
    chk("rst_points",  32'(points),  32'h4);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_alarm",   32'(alarm),   32'h0);

    // Row rotation over two full scans
    for (int i = 0; i < 8; i++) begin
      stick();
      chk("scan_row", 32'(keypadr), 32'(4'b0001 << ((i + 1) % 4)));
    end

    // Entry 1,2,3,0 then run
    press_digit(1); press_digit(2); press_digit(3); press_digit(0);
    chk("entry_1230", 32'(min_sec), 32'h1230);
    press(11);
    chk("go_running", 32'(running), 32'h1);
    chk("go_colon",   32'(points),  32'h4);
    tick1();
    chk("dec_1229",   32'(min_sec), 32'h1229);
    chk("colon_tog",  32'(points),  32'h0);
    press(9);
    chk("clr_idle",   32'(running), 32'h0);
    chk("clr_zero",   32'(min_sec), 32'h0);

    // 01:00 -> 00:59
    press_digit(1); press_digit(0); press_digit(0);
    press(11);
    tick1();
    chk("dec_0059", 32'(min_sec), 32'h0059);
    press(9);

    // 10:00 -> 09:59
    press_digit(1); press_digit(0); press_digit(0); press_digit(0);
    chk("entry_1000", 32'(min_sec), 32'h1000);
    press(11);
    tick1();
    chk("dec_0959", 32'(min_sec), 32'h0959);
    press(9);

    // 00:01 -> alarm for ASECS ticks
    press_digit(1);
    press(11);
    tick1();
    chk("alarm_on",     32'(alarm),   32'h1);
    chk("alarm_ms",     32'(min_sec), 32'h0);
    chk("alarm_notrun", 32'(running), 32'h0);
    repeat (ASECS - 1) tick1();
    chk("alarm_hold9",  32'(alarm),   32'h1);
    tick1();
    chk("alarm_off",    32'(alarm),   32'h0);
    chk("alarm_colon",  32'(points),  32'h4);

    // Bounce on key 5 gives nothing; long hold gives one event
    press_digit(1);
    key_idx = 4; scans(3);
    key_idx = -1; scans(1);
    key_idx = 4; scans(3);
    key_idx = -1; scans(DEB + 1);
    chk("bounce_none", 32'(min_sec), 32'h0001);
    key_idx = 4; scans(20);
    key_idx = -1; scans(DEB + 1);
    chk("hold_once", 32'(min_sec), 32'h0015);
    press(9);

    // Seconds clamp on GO
    press_digit(7); press_digit(5);
    chk("entry_0075", 32'(min_sec), 32'h0075);
    press(11);
    chk("clamp_0059", 32'(min_sec), 32'h0059);
    chk("clamp_run",  32'(running), 32'h1);
    press(9);

    // GO coincident with tick at 00:10
    press_digit(1); press_digit(0);
    press(11);
    key_idx = 11;
    repeat (4 * (DEB - 1) + 3) stick();
    @(negedge clk) scan_tick = 1'b1;
    @(negedge clk) begin scan_tick = 1'b0; tick_1hz = 1'b1; end
    @(negedge clk) tick_1hz = 1'b0;
    key_idx = -1;
    scans(DEB + 1);
    chk("coinc_ms",    32'(min_sec), 32'h0009);
    chk("coinc_pause", 32'(running), 32'h0);
    chk("coinc_colon", 32'(points),  32'h4);
    tick1();
    chk("pause_frozen", 32'(min_sec), 32'h0009);
    press(11);
    chk("resume_run", 32'(running), 32'h1);
    press(9);

    // GO with 00:00 ignored
    press(11);
    chk("go_zero_idle", 32'(running), 32'h0);
    chk("go_zero_ms",   32'(min_sec), 32'h0);

    // Reset mid-countdown
    press_digit(5);
    press(11);
    tick1();
    chk("pre_rst_ms", 32'(min_sec), 32'h0004);
    do_reset();
    chk("midrst_ms",  32'(min_sec), 32'h0);
    chk("midrst_run", 32'(running), 32'h0);
    chk("midrst_row", 32'(keypadr), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
